inject_scheduler_5: RTL
=======================

# inject_scheduler_5

Traffic-injection scheduler for the 5-router NoC demo. It queues injection requests of (target router, 6-bit payload) and replays them into the network one at a time. Each packet is driven as a `{valid, payload}` word on exactly one router input for a programmed number of cycles, followed by a programmed idle gap. It replaces single-shot manual injection, so that bursts can be staged from the board switches and keys and then released under one `start` control.

## Interface
Parameters:
- N2, 7: packet width; bit N2-1 is the valid/emulation bit, bits N2-2:0 are the payload (two 3-bit step counts).
- DEPTH, 8: request FIFO depth, a power of two.
- HOLD, 4: cycles each packet is presented; must be ≥1.
- GAP, 2: forced all-zero cycles after each packet; may be 0.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- push  in  1  single-cycle request strobe, already edge-detected upstream.
- push_router  in  3  target router, 0..4.
- push_data  in  N2-1  payload.
- start  in  1  level; dispatch is enabled while high.
- out_router1..out_router5  out  N2 each  router injection words; registered.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- busy  out  1  FSM is not in IDLE.
- sent_count  out  8  number of packets completed; wraps modulo 256.
- err_overflow  out  1  sticky; set when a push is dropped because the FIFO is full.
- err_range  out  1  sticky; set when a push is dropped because push_router > 4.

## Operation
- **FIFO.** Circular buffer of DEPTH entries, each {router[2:0], data[N2-2:0]}. It has read/write pointers and an occupancy count of width log2(DEPTH)+1.
- **Push acceptance.** A push is accepted when `push && !full && push_router <= 4`. `full` is the registered value from before the edge.
  - A push while full is dropped and sets err_overflow. This holds even if a pop occurs in the same cycle.
  - A push with router 5..7 is dropped, sets err_range, and leaves occupancy unchanged.
  - If both error conditions hold, both flags set.
- **Simultaneous push and pop** when not full: both take effect and occupancy is unchanged.
- **FSM states:** IDLE, HOLD, GAP.
  - IDLE: if `start && !empty`, pop the head into the holding register (router, data), load hold_cnt = HOLD-1, and go to HOLD. Otherwise stay in IDLE.
  - HOLD: the selected out_router<r+1> = {1'b1, data}; all other router outputs are 0. Decrement hold_cnt. When hold_cnt = 0:
    - increment sent_count;
    - if GAP > 0, load gap_cnt = GAP-1 and go to GAP;
    - otherwise go to IDLE.
  - GAP: all router outputs are 0. Decrement gap_cnt. At 0, go to IDLE.
- **Deasserting `start`** only blocks the IDLE→HOLD transition. A packet already in HOLD or GAP completes normally.
- **Output guarantees:**
  - At most one out_router word is non-zero in any cycle.
  - The valid bit is never set outside HOLD.
- **Error flags** clear only on rst.

## Timing
- **Reset values:**
  - all out_router = 0;
  - full = 0, empty = 1, busy = 0;
  - sent_count = 0;
  - err_overflow = 0, err_range = 0.
- **Reset effects:** FIFO pointers and count are cleared and the FSM goes to IDLE.
- **Reset mid-packet:** the outputs are 0 in the cycle after the rst edge. Queued entries are discarded.
- **Push to visibility:** a push accepted at edge t updates empty/full and occupancy after edge t.
- **Push to injection latency:** with the FSM in IDLE and start high, a push at edge t gives:
  - IDLE sees the entry and pops it at edge t+1;
  - the valid packet word is visible after edge t+2.
  - Push-to-injection latency is therefore 2 cycles.
- **Packet duration:** each packet is visible for exactly HOLD cycles.
- **Gap between packets:** back-to-back packets are separated by exactly GAP+1 all-zero cycles (GAP cycles plus one IDLE decision cycle).
- **sent_count** updates on the same edge that ends the HOLD state.
- **busy** is high from the edge entering HOLD through the last GAP cycle.

## Test plan
- **Reset and single packet.** After reset, push (router=2, data=6'b001010) with start=1 and HOLD=4, GAP=2.
  - out_router3 = 7'b1001010 for 4 cycles, starting 2 cycles after the push.
  - All other outputs stay 0.
  - sent_count = 1; empty = 1 afterwards.
- **Burst ordering.** With start=0, push routers 0,1,2,3,4 with data 1..5, then raise start.
  - Packets appear on out_router1..5 in order with data 1..5.
  - Each packet lasts 4 cycles, separated by 3 zero cycles.
  - sent_count = 5.
- **Overflow.** With start=0, push 9 entries (DEPTH=8).
  - full = 1 after the 8th push.
  - The 9th push sets err_overflow and occupancy stays 8.
  - After start, exactly 8 packets are sent and the 9th payload never appears.
- **Range error.** Push router=5, then router=4.
  - err_range = 1.
  - Only one packet is injected, on out_router5.
  - sent_count = 1.
- **Start drop and reset mid-operation.** Queue 3 packets.
  - Drop start during the first HOLD: the first packet completes and the FSM idles with 2 entries queued.
  - Raise start, then assert rst during the second HOLD: all outputs are 0 on the next cycle, empty = 1, sent_count = 0, and no further packets are sent.
- **GAP=0 and sent_count wrap.** With GAP=0, run 256 packets.
  - Inter-packet zero spacing is exactly 1 cycle.
  - sent_count wraps from 255 to 0.

Source files
------------

// File: rtl/inject_scheduler_5.sv
// Traffic-injection scheduler: queues (router, payload) requests and replays each one on a
// single router input for HOLD cycles, followed by GAP forced-idle cycles.
module inject_scheduler_5 #(
  parameter int unsigned N2    = 7,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned HOLD  = 4,
  parameter int unsigned GAP   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [2:0]    push_router,
  input  logic [N2-2:0] push_data,
  input  logic          start,
  output logic [N2-1:0] out_router1,
  output logic [N2-1:0] out_router2,
  output logic [N2-1:0] out_router3,
  output logic [N2-1:0] out_router4,
  output logic [N2-1:0] out_router5,
  output logic          full,
  output logic          empty,
  output logic          busy,
  output logic [7:0]    sent_count,
  output logic          err_overflow,
  output logic          err_range
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(HOLD + GAP + 1);
  localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

  state_e               state_q;
  logic [2:0]           rmem [DEPTH];
  logic [N2-2:0]        dmem [DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count_q;
  logic [CntW-1:0]      cnt_q;
  logic [2:0]           cur_router_q;
  logic [N2-2:0]        cur_data_q;
  logic [4:0][N2-1:0]   out_q;
  logic [7:0]           sent_q;
  logic                 err_overflow_q, err_range_q;
  logic                 range_bad, push_ok, pop;

  assign full      = (count_q == FullCnt);
  assign empty     = (count_q == '0);
  assign busy      = (state_q != StIdle);
  assign range_bad = (push_router > 3'd4);
  assign push_ok   = push && !full && !range_bad;
  assign pop       = (state_q == StIdle) && start && !empty;

  assign out_router1  = out_q[0];
  assign out_router2  = out_q[1];
  assign out_router3  = out_q[2];
  assign out_router4  = out_q[3];
  assign out_router5  = out_q[4];
  assign sent_count   = sent_q;
  assign err_overflow = err_overflow_q;
  assign err_range    = err_range_q;

  // Entry storage carries no reset; pointers and occupancy define what is live.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      rmem[wr_ptr_q] <= push_router;
      dmem[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      err_overflow_q <= 1'b0;
      err_range_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push_ok) count_q <= count_q - 1'b1;
      // A full FIFO rejects the push even when a pop frees a slot on the same edge.
      if (push && full)      err_overflow_q <= 1'b1;
      if (push && range_bad) err_range_q    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      cur_router_q <= '0;
      cur_data_q   <= '0;
      out_q        <= '0;
      sent_q       <= '0;
    end else begin
      // Output words trail the state by one cycle, giving the two-cycle push-to-inject latency.
      for (int i = 0; i < 5; i++) begin
        out_q[i] <= (state_q == StHold && cur_router_q == 3'(i)) ? {1'b1, cur_data_q} : '0;
      end
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            cur_router_q <= rmem[rd_ptr_q];
            cur_data_q   <= dmem[rd_ptr_q];
            cnt_q        <= CntW'(HOLD - 1);
            state_q      <= StHold;
          end
        end
        StHold: begin
          if (cnt_q == '0) begin
            sent_q <= sent_q + 8'd1;
            if (GAP > 0) begin
              cnt_q   <= CntW'(GAP - 1);
              state_q <= StGap;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StGap: begin
          if (cnt_q == '0) state_q <= StIdle;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
